pdm_mic_ctrl: RTL and testbench

Sequencer and sample buffer for the PDM microphone path. Generates the microphone bit clock and the per-bit sample strobe for the decimation filter. Runs a power-up/wake state machine that discards unsettled samples. Buffers the filter's PCM output in a small FIFO with a valid/ready handshake toward the audio consumer (CPU bus bridge or LED effects engine).

---
 rtl/pdm_mic_ctrl.sv | 145 ++++++++++++++
 tb/tb_pdm_mic_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_ctrl.sv
// rtl/pdm_mic_ctrl.sv - PDM mic clock/strobe sequencer, wake FSM and PCM sample FIFO
// Define PDM_MIC_CTRL_GAIN_EN to apply a saturating left-shift gain to samples before the FIFO.
module pdm_mic_ctrl #(
  parameter int SAMPLE_DEPTH = 16,
  parameter int CLK_DIV      = 4,
  parameter int WAKE_CYCLES  = 1024,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [1:0]              gain,
  output logic                    mic_clk,
  output logic                    bit_stb,
  input  logic [SAMPLE_DEPTH-1:0] pcm_in,
  input  logic                    pcm_stb,
  output logic [SAMPLE_DEPTH-1:0] pcm_data,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    overflow,
  input  logic                    overflow_clr,
  output logic                    running
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int WW = $clog2(WAKE_CYCLES) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic [1:0] {S_OFF, S_WAKE, S_RUN, S_STOP} state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic [WW-1:0]     wake_cnt;
  logic              period_end;
  logic              wake_done;

  assign period_end = (cnt == CW'(CLK_DIV - 1));
  assign wake_done  = bit_stb && (wake_cnt == WW'(WAKE_CYCLES - 1));
  assign running    = (state == S_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_OFF;
    else      state <= state_next;
  end

  // STOP only exits at the end of a period so mic_clk never emits a runt high pulse.
  always_comb begin
    state_next = state;
    case (state)
      S_OFF:   if (enable) state_next = S_WAKE;
      S_WAKE:  begin
        if (!enable)        state_next = S_STOP;
        else if (wake_done) state_next = S_RUN;
      end
      S_RUN:   if (!enable) state_next = S_STOP;
      S_STOP:  if (period_end) state_next = S_OFF;
      default: state_next = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      mic_clk <= 1'b0;
      bit_stb <= 1'b0;
    end else if (state == S_OFF) begin
      cnt     <= '0;
      mic_clk <= 1'b0;
      bit_stb <= 1'b0;
    end else begin
      cnt     <= period_end ? '0 : cnt + CW'(1);
      mic_clk <= (cnt >= CW'(CLK_DIV / 2));
      bit_stb <= period_end;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          wake_cnt <= '0;
    else if (state == S_OFF)           wake_cnt <= '0;
    else if (state == S_WAKE && bit_stb) wake_cnt <= wake_cnt + WW'(1);
  end

  logic [SAMPLE_DEPTH-1:0] wr_data;

`ifdef PDM_MIC_CTRL_GAIN_EN
  localparam int XW = SAMPLE_DEPTH + 3;
  logic [XW-1:0] shifted;

  // Bits above the sign position must all match the sign, otherwise the shift overflowed.
  always_comb begin
    shifted = {{3{pcm_in[SAMPLE_DEPTH-1]}}, pcm_in} << gain;
    if (shifted[XW-1] && !(&shifted[XW-1:SAMPLE_DEPTH-1]))
      wr_data = {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};
    else if (!shifted[XW-1] && (|shifted[XW-1:SAMPLE_DEPTH-1]))
      wr_data = {1'b0, {(SAMPLE_DEPTH-1){1'b1}}};
    else
      wr_data = shifted[SAMPLE_DEPTH-1:0];
  end
`else
  logic unused_gain;
  assign unused_gain = ^gain;
  assign wr_data     = pcm_in;
`endif

  logic [SAMPLE_DEPTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;
  logic [NW-1:0]           count;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    wr_en;
  logic                    drop;

  assign push      = (state == S_RUN) && pcm_stb;
  assign pop       = pcm_valid && pcm_ready;
  assign full      = (count == NW'(FIFO_DEPTH));
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign pcm_valid = (count != '0);
  assign pcm_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + NW'(1);
      else if (!wr_en && pop) count <= count - NW'(1);
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// tb/tb_pdm_mic_ctrl.sv - directed self-checking bench for pdm_mic_ctrl
module tb_pdm_mic_ctrl;

  localparam int SD = 16;
  localparam int CD = 4;
  localparam int WC = 8;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    gain;
  logic          mic_clk;
  logic          bit_stb;
  logic [SD-1:0] pcm_in;
  logic          pcm_stb;
  logic [SD-1:0] pcm_data;
  logic          pcm_valid;
  logic          pcm_ready;
  logic          overflow;
  logic          overflow_clr;
  logic          running;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pdm_mic_ctrl #(
    .SAMPLE_DEPTH(SD),
    .CLK_DIV(CD),
    .WAKE_CYCLES(WC),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .gain(gain),
    .mic_clk(mic_clk),
    .bit_stb(bit_stb),
    .pcm_in(pcm_in),
    .pcm_stb(pcm_stb),
    .pcm_data(pcm_data),
    .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready),
    .overflow(overflow),
    .overflow_clr(overflow_clr),
    .running(running)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_running(output int k);
    k = 0;
    while (running !== 1'b1 && k < 200) begin
      step();
      k++;
    end
  endtask

  task automatic push_one(input logic [SD-1:0] v);
    pcm_in  = v;
    pcm_stb = 1'b1;
    step();
    pcm_stb = 1'b0;
  endtask

  task automatic test_reset();
    int hi_mic = 0;
    int hi_stb = 0;
    int hi_valid = 0;
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if ({mic_clk, bit_stb, pcm_valid, overflow, running} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=00000", {mic_clk, bit_stb, pcm_valid, overflow, running});
    end
    checks++;
    if (pcm_data !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0000", pcm_data);
    end
    rst = 1'b1;
    repeat (100) begin
      step();
      if (mic_clk !== 1'b0) hi_mic++;
      if (bit_stb !== 1'b0) hi_stb++;
      if (pcm_valid !== 1'b0) hi_valid++;
    end
    checks++;
    if (hi_mic != 0) begin errors++; $display("FAIL idle_mic_clk got=%0d want=0", hi_mic); end
    checks++;
    if (hi_stb != 0) begin errors++; $display("FAIL idle_bit_stb got=%0d want=0", hi_stb); end
    checks++;
    if (hi_valid != 0) begin errors++; $display("FAIL idle_pcm_valid got=%0d want=0", hi_valid); end
  endtask

  task automatic test_wake();
    int k = 0;
    int first_rise = -1;
    int second_rise = -1;
    int run_k = -1;
    int nstb = 0;
    int valid_seen = 0;
    logic prev_mic = 1'b0;
    logic prev_stb = 1'b0;
    logic [SD-1:0] val = 16'h0001;
    enable = 1'b1;
    step();
    while (k < 200 && run_k < 0) begin
      if (running === 1'b1) begin
        run_k = k;
      end else begin
        if (mic_clk === 1'b1 && prev_mic === 1'b0) begin
          if (first_rise < 0) first_rise = k;
          else if (second_rise < 0) second_rise = k;
        end
        prev_mic = mic_clk;
        if (bit_stb === 1'b1) nstb++;
        prev_stb = bit_stb;
        if (pcm_valid !== 1'b0) valid_seen++;
        pcm_stb = (k % 4 == 0);
        pcm_in  = val;
        if (k % 4 == 0) val++;
        step();
        k++;
      end
    end
    pcm_stb = 1'b0;
    checks++;
    if (first_rise != CD / 2 + 1) begin errors++; $display("FAIL wake_first_rise got=%0d want=%0d", first_rise, CD / 2 + 1); end
    checks++;
    if (second_rise - first_rise != CD) begin errors++; $display("FAIL wake_mic_period got=%0d want=%0d", second_rise - first_rise, CD); end
    checks++;
    if (run_k != 33) begin errors++; $display("FAIL wake_run_cycle got=%0d want=33", run_k); end
    checks++;
    if (nstb != WC || prev_stb !== 1'b1) begin errors++; $display("FAIL wake_stb_count got=%0d/%b want=%0d/1", nstb, prev_stb, WC); end
    checks++;
    if (valid_seen != 0 || pcm_valid !== 1'b0) begin errors++; $display("FAIL wake_discard got=%0d want=0", valid_seen); end
    push_one(16'h1234);
    checks++;
    if (pcm_valid !== 1'b1 || pcm_data !== 16'h1234) begin
      errors++;
      $display("FAIL first_sample got=%b/%h want=1/1234", pcm_valid, pcm_data);
    end
    pcm_ready = 1'b1;
    step();
    pcm_ready = 1'b0;
    checks++;
    if (pcm_valid !== 1'b0) begin errors++; $display("FAIL first_pop got=%b want=0", pcm_valid); end
  endtask

  task automatic test_overflow();
    pcm_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      pcm_in       = SD'(i);
      pcm_stb      = 1'b1;
      overflow_clr = (i == 10);
      step();
      if (i == 8) begin
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got=%b want=0", overflow); end
      end
      if (i == 9) begin
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", overflow); end
      end
    end
    pcm_stb      = 1'b0;
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clr got=%b want=1", overflow); end
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b want=0", overflow); end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (pcm_valid !== 1'b1 || pcm_data !== SD'(i)) begin
        errors++;
        $display("FAIL ovf_drain[%0d] got=%b/%h want=1/%h", i, pcm_valid, pcm_data, SD'(i));
      end
      pcm_ready = 1'b1;
      step();
    end
    pcm_ready = 1'b0;
    checks++;
    if (pcm_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_empty got=%b want=0", pcm_valid); end
  endtask

  task automatic test_full_push_pop();
    int n = 0;
    logic [SD-1:0] exp_v = 16'h0022;
    for (int i = 0; i < 8; i++) push_one(SD'(16'h21 + i));
    pcm_in    = 16'h0029;
    pcm_stb   = 1'b1;
    pcm_ready = 1'b1;
    step();
    pcm_stb   = 1'b0;
    pcm_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf got=%b want=0", overflow); end
    while (pcm_valid === 1'b1 && n < 20) begin
      checks++;
      if (pcm_data !== exp_v) begin errors++; $display("FAIL full_pushpop_order got=%h want=%h", pcm_data, exp_v); end
      exp_v++;
      n++;
      pcm_ready = 1'b1;
      step();
    end
    pcm_ready = 1'b0;
    checks++;
    if (n != 8) begin errors++; $display("FAIL full_pushpop_count got=%0d want=8", n); end
  endtask

  task automatic test_gain();
    logic [SD-1:0] exp_v [3];
`ifdef PDM_MIC_CTRL_GAIN_EN
    exp_v[0] = 16'h4000; exp_v[1] = 16'h7FFF; exp_v[2] = 16'h8000;
`else
    exp_v[0] = 16'h1000; exp_v[1] = 16'h3000; exp_v[2] = 16'hC000;
`endif
    gain = 2'd2;
    push_one(16'h1000);
    push_one(16'h3000);
    push_one(16'hC000);
    gain = 2'd0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pcm_valid !== 1'b1 || pcm_data !== exp_v[i]) begin
        errors++;
        $display("FAIL gain[%0d] got=%b/%h want=1/%h", i, pcm_valid, pcm_data, exp_v[i]);
      end
      pcm_ready = 1'b1;
      step();
    end
    pcm_ready = 1'b0;
  endtask

  task automatic test_stop();
    int n = 0;
    int hi = 0;
    int last_hi = -1;
    int k;
    push_one(16'h0051);
    push_one(16'h0052);
    push_one(16'h0053);
    while (bit_stb !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL stop_sync got=timeout want=bit_stb"); end
    step();
    enable = 1'b0;
    step();
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL stop_running got=%b want=0", running); end
    for (int s = 0; s < 12; s++) begin
      if (mic_clk === 1'b1) begin hi++; last_hi = s; end
      step();
    end
    checks++;
    if (hi != CD / 2 || last_hi != 2) begin
      errors++;
      $display("FAIL stop_high_phase got=%0d@%0d want=%0d@2", hi, last_hi, CD / 2);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pcm_valid !== 1'b1 || pcm_data !== SD'(16'h51 + i)) begin
        errors++;
        $display("FAIL stop_drain[%0d] got=%b/%h want=1/%h", i, pcm_valid, pcm_data, SD'(16'h51 + i));
      end
      pcm_ready = 1'b1;
      step();
    end
    pcm_ready = 1'b0;
    checks++;
    if (pcm_valid !== 1'b0) begin errors++; $display("FAIL stop_drain_empty got=%b want=0", pcm_valid); end
    enable = 1'b1;
    step();
    wait_running(k);
    checks++;
    if (k != CD * WC + 1) begin errors++; $display("FAIL rewake_cycles got=%0d want=%0d", k, CD * WC + 1); end
  endtask

  task automatic test_reset_mid();
    push_one(16'h0077);
    checks++;
    if (pcm_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b want=1", pcm_valid); end
    rst = 1'b0;
    #1;
    checks++;
    if ({mic_clk, bit_stb, pcm_valid, overflow, running} !== 5'b0 || pcm_data !== '0) begin
      errors++;
      $display("FAIL mid_reset got=%b/%h want=00000/0000", {mic_clk, bit_stb, pcm_valid, overflow, running}, pcm_data);
    end
    step();
    rst = 1'b1;
    enable = 1'b0;
    step();
  endtask

  initial begin
    rst          = 1'b0;
    enable       = 1'b0;
    gain         = 2'd0;
    pcm_in       = '0;
    pcm_stb      = 1'b0;
    pcm_ready    = 1'b0;
    overflow_clr = 1'b0;
    test_reset();
    test_wake();
    test_overflow();
    test_full_push_pop();
    test_gain();
    test_stop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
